qpsk_frame_deframer: RTL and testbench

Receive-side frame recovery for the QPSK modem. It takes the demodulated dibit stream (one I/Q bit pair per symbol strobe) and hunts for the 8-bit sync header. It then assembles each 40-bit frame MSB-first and presents it as a parallel word with a one-cycle valid. It is the counterpart of the transmit-side framing that serializes para_in[39:0] onto I/Q, and it sits between the demodulator's bit decision and the parallel para_out consumer.

---
 rtl/qpsk_pkg.sv | 23 ++
 rtl/qpsk_frame_deframer_sync_detect.sv | 34 +++
 rtl/qpsk_frame_deframer.sv | 134 +++++++++++++
 tb/tb_qpsk_frame_deframer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// Shared defaults, state encoding and beat-count helpers for the QPSK receive deframer.
package qpsk_pkg;

  localparam int         FRAME_W_DEF  = 40;
  localparam int         HDR_W_DEF    = 8;
  localparam logic [7:0] HDR_DEF      = 8'hCC;
  localparam int         MISS_MAX_DEF = 3;

  localparam int PAY_BEATS = (FRAME_W_DEF - HDR_W_DEF) / 2;
  localparam int HDR_BEATS = HDR_W_DEF / 2;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    VERIFY  = 2'd2
  } state_e;

  // Terminal value of the 5-bit beat counter for a phase of 'beats' dibits.
  function automatic logic [4:0] beat_last(input int beats);
    return 5'(beats - 1);
  endfunction

endpackage

// File: rtl/qpsk_frame_deframer_sync_detect.sv
// Dibit sliding window over the last HDR_W received bits with a header comparator.
// window_o/match_o reflect the window as it will be after the current dibit shifts in.
module qpsk_sync_detect #(
  parameter int               HDR_W = 8,
  parameter logic [HDR_W-1:0] HDR   = 8'hCC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_i,
  input  logic             sym_i_i,
  input  logic             sym_q_i,
  output logic [HDR_W-1:0] window_o,
  output logic             match_o
);

  logic [HDR_W-1:0] win_q;
  logic [HDR_W-1:0] win_d;

  always_comb begin
    win_d = {win_q[HDR_W-3:0], sym_i_i, sym_q_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (shift_i) begin
      win_q <= win_d;
    end
  end

  assign window_o = win_d;
  assign match_o  = (win_d == HDR);

endmodule

// File: rtl/qpsk_frame_deframer.sv
// QPSK receive frame recovery: header hunt, payload assembly and flywheel lock tracking.
module qpsk_frame_deframer
  import qpsk_pkg::*;
#(
  parameter int               FRAME_W  = FRAME_W_DEF,
  parameter int               HDR_W    = HDR_W_DEF,
  parameter logic [HDR_W-1:0] HDR      = HDR_DEF,
  parameter int               MISS_MAX = MISS_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dibit_valid,
  input  logic               dibit_i,
  input  logic               dibit_q,
  output logic [FRAME_W-1:0] para_out,
  output logic               para_valid,
  output logic               hdr_err,
  output logic               lock
);

  localparam int         PAY_W    = FRAME_W - HDR_W;
  localparam int         MISS_W   = $clog2(MISS_MAX + 1);
  localparam logic [4:0] PAY_LAST = beat_last(PAY_W / 2);
  localparam logic [4:0] HDR_LAST = beat_last(HDR_W / 2);

  state_e             state_q;
  logic [4:0]         beat_q;
  logic [MISS_W-1:0]  miss_q;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] para_out_q;
  logic               para_valid_q;
  logic               hdr_err_q;
  logic               lock_q;
  logic               hdr_bad_q;

  logic [FRAME_W-1:0] frame_d;
  logic [MISS_W:0]    miss_inc_d;
  logic [HDR_W-1:0]   win_s;
  logic               match_s;

  qpsk_sync_detect #(
    .HDR_W (HDR_W),
    .HDR   (HDR)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_i  (dibit_valid),
    .sym_i_i  (dibit_i),
    .sym_q_i  (dibit_q),
    .window_o (win_s),
    .match_o  (match_s)
  );

  // Header stays parked in the MSBs; only the payload field shifts.
  always_comb begin
    frame_d    = {frame_q[FRAME_W-1 -: HDR_W], frame_q[PAY_W-3:0], dibit_i, dibit_q};
    miss_inc_d = {1'b0, miss_q} + {{MISS_W{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      beat_q       <= 5'd0;
      miss_q       <= '0;
      frame_q      <= '0;
      para_out_q   <= '0;
      para_valid_q <= 1'b0;
      hdr_err_q    <= 1'b0;
      lock_q       <= 1'b0;
      hdr_bad_q    <= 1'b0;
    end else begin
      para_valid_q <= 1'b0;
      hdr_err_q    <= 1'b0;
      if (dibit_valid) begin
        case (state_q)
          HUNT: begin
            if (match_s) begin
              state_q   <= COLLECT;
              beat_q    <= 5'd0;
              frame_q   <= {win_s, {PAY_W{1'b0}}};
              hdr_bad_q <= 1'b0;
            end
          end
          COLLECT: begin
            frame_q <= frame_d;
            if (beat_q == PAY_LAST) begin
              para_out_q   <= frame_d;
              para_valid_q <= 1'b1;
              hdr_err_q    <= hdr_bad_q;
              lock_q       <= 1'b1;
              beat_q       <= 5'd0;
              state_q      <= VERIFY;
            end else begin
              beat_q <= beat_q + 5'd1;
            end
          end
          VERIFY: begin
            if (beat_q == HDR_LAST) begin
              beat_q <= 5'd0;
              if (match_s) begin
                miss_q    <= '0;
                state_q   <= COLLECT;
                frame_q   <= {win_s, {PAY_W{1'b0}}};
                hdr_bad_q <= 1'b0;
              end else if (int'(miss_inc_d) < MISS_MAX) begin
                // Flywheel: keep alignment, tag the frame with the bad header.
                miss_q    <= miss_inc_d[MISS_W-1:0];
                state_q   <= COLLECT;
                frame_q   <= {win_s, {PAY_W{1'b0}}};
                hdr_bad_q <= 1'b1;
              end else begin
                miss_q  <= '0;
                lock_q  <= 1'b0;
                state_q <= HUNT;
              end
            end else begin
              beat_q <= beat_q + 5'd1;
            end
          end
          default: begin
            state_q <= HUNT;
            beat_q  <= 5'd0;
          end
        endcase
      end
    end
  end

  assign para_out   = para_out_q;
  assign para_valid = para_valid_q;
  assign hdr_err    = hdr_err_q;
  assign lock       = lock_q;

endmodule

// File: tb/tb_qpsk_frame_deframer.sv
// Directed self-checking bench for qpsk_frame_deframer.
module tb_qpsk_frame_deframer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dibit_valid = 1'b0;
  logic        dibit_i = 1'b0;
  logic        dibit_q = 1'b0;
  logic [39:0] para_out;
  logic        para_valid;
  logic        hdr_err;
  logic        lock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [39:0] got_f[$];
  logic        got_e[$];
  int          wide_cnt = 0;
  int          stray_cnt = 0;
  logic        pv_prev = 1'b0;

  always #5 clk = ~clk;

  qpsk_frame_deframer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dibit_valid (dibit_valid),
    .dibit_i     (dibit_i),
    .dibit_q     (dibit_q),
    .para_out    (para_out),
    .para_valid  (para_valid),
    .hdr_err     (hdr_err),
    .lock        (lock)
  );

  // Frame capture and pulse-shape watch, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (para_valid) begin
      got_f.push_back(para_out);
      got_e.push_back(hdr_err);
      if (pv_prev) wide_cnt++;
    end else if (hdr_err) begin
      stray_cnt++;
    end
    pv_prev = para_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a falling edge; returns at a falling edge 'gap' cycles later.
  task automatic send_dibit(input logic bi, input logic bq, input int gap);
    dibit_i = bi;
    dibit_q = bq;
    dibit_valid = 1'b1;
    @(negedge clk);
    dibit_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [39:0] f, input int gap);
    for (int k = 0; k < 20; k++) send_dibit(f[39-2*k], f[38-2*k], gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got_f.delete();
    got_e.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (para_out !== 40'h0) begin n_bad++; $display("FAIL reset_para_out got=%h exp=0", para_out); end
    n_cmp++; if (para_valid !== 1'b0) begin n_bad++; $display("FAIL reset_para_valid got=%b exp=0", para_valid); end
    n_cmp++; if (hdr_err !== 1'b0) begin n_bad++; $display("FAIL reset_hdr_err got=%b exp=0", hdr_err); end
    n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL reset_lock got=%b exp=0", lock); end
    rst_n = 1'b1;
    @(negedge clk);
    got_f.delete();
    got_e.delete();
  endtask

  task automatic test_basic();
    logic [39:0] f;
    f = 40'hCC17181914;
    for (int k = 0; k < 19; k++) send_dibit(f[39-2*k], f[38-2*k], 4);
    n_cmp++; if (para_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got=%b exp=0", para_valid); end
    dibit_i = f[1];
    dibit_q = f[0];
    dibit_valid = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (para_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%b exp=1", para_valid); end
    n_cmp++; if (para_out !== 40'hCC17181914) begin n_bad++; $display("FAIL basic_para_out got=%h exp=cc17181914", para_out); end
    n_cmp++; if (hdr_err !== 1'b0) begin n_bad++; $display("FAIL basic_hdr_err got=%b exp=0", hdr_err); end
    n_cmp++; if (lock !== 1'b1) begin n_bad++; $display("FAIL basic_lock got=%b exp=1", lock); end
    @(negedge clk);
    dibit_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (para_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width got=%b exp=0", para_valid); end
    n_cmp++; if (para_out !== 40'hCC17181914) begin n_bad++; $display("FAIL basic_hold got=%h exp=cc17181914", para_out); end
    @(negedge clk);
    n_cmp++; if (got_f.size() !== 1) begin n_bad++; $display("FAIL basic_count got=%0d exp=1", got_f.size()); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] pre;
    pre = 12'b01_10_01_11_10_01;
    do_reset();
    for (int k = 0; k < 6; k++) send_dibit(pre[11-2*k], pre[10-2*k], 1);
    send_frame(40'hCC17181914, 1);
    send_frame(40'hCC00FF00AA, 1);
    repeat (2) @(negedge clk);
    n_cmp++; if (got_f.size() !== 2) begin n_bad++; $display("FAIL b2b_count got=%0d exp=2", got_f.size()); end
    n_cmp++; if (got_f[0] !== 40'hCC17181914) begin n_bad++; $display("FAIL b2b_frame0 got=%h exp=cc17181914", got_f[0]); end
    n_cmp++; if (got_f[1] !== 40'hCC00FF00AA) begin n_bad++; $display("FAIL b2b_frame1 got=%h exp=cc00ff00aa", got_f[1]); end
    n_cmp++; if ({got_e[0], got_e[1]} !== 2'b00) begin n_bad++; $display("FAIL b2b_hdr_err got=%b%b exp=00", got_e[0], got_e[1]); end
    n_cmp++; if (lock !== 1'b1) begin n_bad++; $display("FAIL b2b_lock got=%b exp=1", lock); end
  endtask

  task automatic test_flywheel();
    got_f.delete();
    got_e.delete();
    send_frame(40'h3312345678, 2);
    repeat (2) @(negedge clk);
    n_cmp++; if (got_f.size() !== 1) begin n_bad++; $display("FAIL fly_count1 got=%0d exp=1", got_f.size()); end
    n_cmp++; if (got_f[0] !== 40'h3312345678) begin n_bad++; $display("FAIL fly_bad_frame got=%h exp=3312345678", got_f[0]); end
    n_cmp++; if (got_e[0] !== 1'b1) begin n_bad++; $display("FAIL fly_bad_err got=%b exp=1", got_e[0]); end
    n_cmp++; if (lock !== 1'b1) begin n_bad++; $display("FAIL fly_lock_kept got=%b exp=1", lock); end
    send_frame(40'hCC01020304, 1);
    send_frame(40'h5512345678, 1);
    send_frame(40'h6687654321, 1);
    for (int k = 0; k < 4; k++) send_dibit(1'b0, 1'b0, 1);
    n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL fly_unlock got=%b exp=0", lock); end
    for (int k = 0; k < 16; k++) send_dibit(1'b0, 1'b0, 1);
    n_cmp++; if (got_f.size() !== 4) begin n_bad++; $display("FAIL fly_no_third got=%0d exp=4", got_f.size()); end
    send_frame(40'hCC0A0B0C0D, 1);
    repeat (2) @(negedge clk);
    n_cmp++; if (got_f.size() !== 5) begin n_bad++; $display("FAIL fly_count got=%0d exp=5", got_f.size()); end
    n_cmp++; if (got_f[1] !== 40'hCC01020304 || got_e[1] !== 1'b0) begin n_bad++; $display("FAIL fly_good got=%h/%b exp=cc01020304/0", got_f[1], got_e[1]); end
    n_cmp++; if (got_f[2] !== 40'h5512345678 || got_e[2] !== 1'b1) begin n_bad++; $display("FAIL fly_miss1 got=%h/%b exp=5512345678/1", got_f[2], got_e[2]); end
    n_cmp++; if (got_f[3] !== 40'h6687654321 || got_e[3] !== 1'b1) begin n_bad++; $display("FAIL fly_miss2 got=%h/%b exp=6687654321/1", got_f[3], got_e[3]); end
    n_cmp++; if (got_f[4] !== 40'hCC0A0B0C0D || got_e[4] !== 1'b0) begin n_bad++; $display("FAIL fly_reacq got=%h/%b exp=cc0a0b0c0d/0", got_f[4], got_e[4]); end
    n_cmp++; if (lock !== 1'b1) begin n_bad++; $display("FAIL fly_relock got=%b exp=1", lock); end
  endtask

  task automatic test_reset_mid();
    logic [39:0] f;
    f = 40'hCC11223344;
    got_f.delete();
    got_e.delete();
    for (int k = 0; k < 10; k++) send_dibit(f[39-2*k], f[38-2*k], 2);
    n_cmp++; if (lock !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_lock got=%b exp=1", lock); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (para_out !== 40'h0) begin n_bad++; $display("FAIL rmid_para_out got=%h exp=0", para_out); end
    n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL rmid_lock got=%b exp=0", lock); end
    n_cmp++; if ({para_valid, hdr_err} !== 2'b00) begin n_bad++; $display("FAIL rmid_valid_err got=%b%b exp=00", para_valid, hdr_err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 10; k < 20; k++) send_dibit(f[39-2*k], f[38-2*k], 2);
    n_cmp++; if (got_f.size() !== 0) begin n_bad++; $display("FAIL rmid_stale got=%0d exp=0", got_f.size()); end
    send_frame(40'hCC5A5A5A5A, 2);
    repeat (2) @(negedge clk);
    n_cmp++; if (got_f.size() !== 1) begin n_bad++; $display("FAIL rmid_count got=%0d exp=1", got_f.size()); end
    n_cmp++; if (got_f[0] !== 40'hCC5A5A5A5A || got_e[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_frame got=%h/%b exp=cc5a5a5a5a/0", got_f[0], got_e[0]); end
  endtask

  task automatic test_payload_cc();
    got_f.delete();
    got_e.delete();
    send_frame(40'hCCCC0000CC, 1);
    send_frame(40'hCC17181914, 1);
    repeat (2) @(negedge clk);
    n_cmp++; if (got_f.size() !== 2) begin n_bad++; $display("FAIL pcc_count got=%0d exp=2", got_f.size()); end
    n_cmp++; if (got_f[0] !== 40'hCCCC0000CC) begin n_bad++; $display("FAIL pcc_frame0 got=%h exp=cccc0000cc", got_f[0]); end
    n_cmp++; if (got_f[1] !== 40'hCC17181914) begin n_bad++; $display("FAIL pcc_frame1 got=%h exp=cc17181914", got_f[1]); end
    n_cmp++; if ({got_e[0], got_e[1], lock} !== 3'b001) begin n_bad++; $display("FAIL pcc_err_lock got=%b%b%b exp=001", got_e[0], got_e[1], lock); end
  endtask

  // Prefix 11,00 plus the frame's leading 11,00 forms the first header window.
  task automatic test_hunt_offset();
    do_reset();
    send_dibit(1'b1, 1'b1, 1);
    send_dibit(1'b0, 1'b0, 1);
    send_frame(40'hCC17181914, 1);
    repeat (2) @(negedge clk);
    n_cmp++; if (got_f.size() !== 1) begin n_bad++; $display("FAIL hunt_count got=%0d exp=1", got_f.size()); end
    n_cmp++; if (got_f[0] !== 40'hCCC1718191) begin n_bad++; $display("FAIL hunt_frame got=%h exp=ccc1718191", got_f[0]); end
    n_cmp++; if (got_e[0] !== 1'b0 || lock !== 1'b1) begin n_bad++; $display("FAIL hunt_err_lock got=%b%b exp=01", got_e[0], lock); end
  endtask

  task automatic test_pulse_shape();
    n_cmp++; if (wide_cnt !== 0) begin n_bad++; $display("FAIL pulse_wide got=%0d exp=0", wide_cnt); end
    n_cmp++; if (stray_cnt !== 0) begin n_bad++; $display("FAIL hdr_err_stray got=%0d exp=0", stray_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flywheel();
    test_reset_mid();
    test_payload_cc();
    test_hunt_offset();
    test_pulse_shape();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
